// File: rtl/sign_extension_pkg.sv
// Shared load-size encodings and data-path constants.
// The load/store unit reuses these encodings.
package sign_extension_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
endpackage

// File: rtl/sign_extension_core.sv
// Combinational sign extension of a byte or halfword operand held in the low bits of d.
// Word and reserved sizes pass d through unchanged.
module sign_ext_core
    import sign_extension_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] d,
    input  logic [1:0]        size,
    output logic [DATA_W-1:0] ext
);

    always_comb begin
        ext = d;
        case (size)
            SZ_BYTE: ext = {{(DATA_W-BYTE_W){d[BYTE_W-1]}}, d[BYTE_W-1:0]};
            SZ_HALF: ext = {{(DATA_W-HALF_W){d[HALF_W-1]}}, d[HALF_W-1:0]};
            default: ext = d;
        endcase
    end

endmodule

// File: rtl/sign_extension.sv
// Registered sign extension: one enabled flop bank behind sign_ext_core.
// Q is cleared asynchronously by RST, which also overrides E.
module sign_extension
    import sign_extension_pkg::*;
#(
    parameter int DATA_W = 32
) (
    output logic [DATA_W-1:0] Q,
    input  logic [DATA_W-1:0] D,
    input  logic [1:0]        dataSize,
    input  logic              E,
    input  logic              CLK,
    input  logic              RST
);

    logic [DATA_W-1:0] ext;

    sign_ext_core #(.DATA_W(DATA_W)) u_core (
        .d    (D),
        .size (dataSize),
        .ext  (ext)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            Q <= '0;
        else if (E)
            Q <= ext;
    end

endmodule

// File: tb/tb_sign_extension.sv
// Scoreboard bench for sign_extension: stimulus queues expected Q per edge,
// a monitor pops and compares shortly after each rising edge.
module tb_sign_extension;
    import sign_extension_pkg::*;

    logic [31:0] Q;
    logic [31:0] D;
    logic [1:0]  dataSize;
    logic        E;
    logic        CLK;
    logic        RST;

    typedef struct {
        logic [31:0] exp;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    sign_extension #(.DATA_W(32)) dut (
        .Q        (Q),
        .D        (D),
        .dataSize (dataSize),
        .E        (E),
        .CLK      (CLK),
        .RST      (RST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: Q=%08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every entry due at this edge, 2 time units after it.
    always @(posedge CLK) begin
        exp_t e;
        cyc++;
        #2;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check(e.name, Q, e.exp);
        end
    end

    // Drive inputs just after an edge; the result is due at the following edge.
    task automatic drive(input logic [31:0] d, input logic [1:0] sz, input logic e,
                         input logic [31:0] exp, input string name);
        exp_t x;
        @(posedge CLK);
        #1;
        D = d;
        dataSize = sz;
        E = e;
        x.exp = exp; x.due = cyc + 1; x.name = name;
        sb.push_back(x);
    endtask

    initial begin
        exp_t x;
        RST = 1'b1; E = 1'b0; D = 32'h0; dataSize = SZ_BYTE;
        #1;
        check("reset_state", Q, 32'h0000_0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Disabled after reset: Q stays cleared
        drive(32'h0000_FF03, SZ_BYTE, 1'b0, 32'h0000_0000, "hold_after_rst0");
        drive(32'h0000_FF03, SZ_HALF, 1'b0, 32'h0000_0000, "hold_after_rst1");
        drive(32'h0000_FF03, SZ_WORD, 1'b0, 32'h0000_0000, "hold_after_rst2");

        drive(32'h0000_FF03, SZ_BYTE, 1'b1, 32'h0000_0003, "ff03_byte");
        drive(32'h0000_FF03, SZ_HALF, 1'b1, 32'hFFFF_FF03, "ff03_half");
        drive(32'h0000_FF03, SZ_WORD, 1'b1, 32'h0000_FF03, "ff03_word");
        drive(32'h0000_FF03, SZ_RSVD, 1'b1, 32'h0000_FF03, "ff03_rsvd");

        drive(32'hF0E4_7492, SZ_BYTE, 1'b1, 32'hFFFF_FF92, "f0e4_byte");
        drive(32'hF0E4_7492, SZ_HALF, 1'b1, 32'h0000_7492, "f0e4_half");
        drive(32'hF0E4_7492, SZ_WORD, 1'b1, 32'hF0E4_7492, "f0e4_word");
        drive(32'hF0E4_7492, SZ_RSVD, 1'b1, 32'hF0E4_7492, "f0e4_rsvd");

        // Upper bits must not leak into byte/halfword results
        drive(32'hABCD_0080, SZ_BYTE, 1'b1, 32'hFFFF_FF80, "byte_min_neg");
        drive(32'hFFFF_FF7F, SZ_BYTE, 1'b1, 32'h0000_007F, "byte_max_pos");
        drive(32'h1234_7FFF, SZ_HALF, 1'b1, 32'h0000_7FFF, "half_max_pos");
        drive(32'h0000_8000, SZ_HALF, 1'b1, 32'hFFFF_8000, "half_min_neg");

        // Hold with E=0 while D and dataSize wander
        drive(32'hF0E4_7492, SZ_BYTE, 1'b1, 32'hFFFF_FF92, "load_ff92");
        drive(32'h0000_FF03, SZ_BYTE, 1'b0, 32'hFFFF_FF92, "hold_byte");
        drive(32'h0000_FF03, SZ_HALF, 1'b0, 32'hFFFF_FF92, "hold_half");
        drive(32'h0000_FF03, SZ_WORD, 1'b0, 32'hFFFF_FF92, "hold_word");
        drive(32'h0000_FF03, SZ_RSVD, 1'b0, 32'hFFFF_FF92, "hold_rsvd");

        // Asynchronous reset between edges, dominating E
        drive(32'hF0E4_7492, SZ_WORD, 1'b1, 32'hF0E4_7492, "pre_rst_load");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("async_rst", Q, 32'h0000_0000);
        x.exp = 32'h0000_0000; x.due = cyc + 1; x.name = "rst_dominates_e";
        sb.push_back(x);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        D = 32'h0000_FF03; dataSize = SZ_HALF; E = 1'b1;
        x.exp = 32'hFFFF_FF03; x.due = cyc + 1; x.name = "post_rst_load";
        sb.push_back(x);

        // D changes mid-cycle: Q moves only at the next edge
        drive(32'h0000_1234, SZ_WORD, 1'b1, 32'h0000_1234, "load_1234");
        @(posedge CLK);
        #3;
        D = 32'h0000_ABCD;
        #2;
        check("no_midcycle_change", Q, 32'h0000_1234);
        x.exp = 32'h0000_ABCD; x.due = cyc + 1; x.name = "load_abcd";
        sb.push_back(x);
        @(posedge CLK);
        #1;
        E = 1'b0;

        repeat (3) @(posedge CLK);
        #4;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
